// File: rtl/bus_mem_responder.sv
// bus_mem_responder: word-organised memory slave with fixed wait states, byte/half/word access and error completion
//   clk_i/reset_i      : clock, asynchronous active-low reset
//   mrd_i/mwr_i        : read/write request (both high = error request)
//   funct3_i           : RV32I load/store size/sign code
//   byte_addr_i, wd_i  : byte address, right-justified write data
//   rd_o               : read data, held until the next completing read
//   busy_o, rdy_o, err_o : in progress, one-cycle completion strobe, error flag (only with rdy_o)
module bus_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WORDS  = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  mrd_i,
  input  logic                  mwr_i,
  input  logic [2:0]            funct3_i,
  input  logic [31:0]           byte_addr_i,
  input  logic [DATA_WIDTH-1:0] wd_i,
  output logic [DATA_WIDTH-1:0] rd_o,
  output logic                  busy_o,
  output logic                  rdy_o,
  output logic                  err_o
);
  localparam int AW = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
  localparam logic [31:0] WORDS = ADDR_WORDS;
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RMW = 2'd2, DONE = 2'd3;
  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  op_rd, op_wr, err_q, bad, we;
  logic [2:0]            f3;
  logic [31:0]           addr;
  logic [DATA_WIDTH-1:0] wd, cur, merged, ext, wdata;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic [AW-1:0]         widx;
  logic [DATA_WIDTH-1:0] mem [ADDR_WORDS];
  assign widx   = addr[AW+1:2];
  assign cur    = mem[widx];
  assign byte_v = cur[{addr[1:0], 3'b000} +: 8];
  assign half_v = cur[{addr[1], 4'b0000} +: 16];
  assign bad = (op_rd & op_wr)
             | (f3[1:0] == 2'b01 & addr[0])
             | (f3[1:0] == 2'b10 & addr[1:0] != 2'b00)
             | ({2'b00, addr[31:2]} >= WORDS)
             | (op_rd & (f3 == 3'b011 | f3[2:1] == 2'b11))
             | (op_wr & (f3[2] | f3[1:0] == 2'b11));
  assign ext = f3 == 3'b000 ? {{(DATA_WIDTH-8){byte_v[7]}}, byte_v}
             : f3 == 3'b100 ? {{(DATA_WIDTH-8){1'b0}}, byte_v}
             : f3 == 3'b001 ? {{(DATA_WIDTH-16){half_v[15]}}, half_v}
             : f3 == 3'b101 ? {{(DATA_WIDTH-16){1'b0}}, half_v}
             : cur;
  always_comb begin
    merged = cur;
    if (f3[0]) merged[{addr[1], 4'b0000} +: 16] = wd[15:0];
    else       merged[{addr[1:0], 3'b000} +: 8] = wd[7:0];
  end
  // Gating with reset_i keeps an access aborted by reset from reaching storage.
  assign we    = reset_i & (state == RMW | (state == WAIT & cnt == 4'd1 & op_wr & ~bad & f3 == 3'b010));
  assign wdata = state == RMW ? merged : wd;
  always_ff @(posedge clk_i) if (we) mem[widx] <= wdata;
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= IDLE;
      cnt   <= '0;
      rd_o  <= '0;
      err_q <= 1'b0;
      op_rd <= 1'b0;
      op_wr <= 1'b0;
      f3    <= '0;
      addr  <= '0;
      wd    <= '0;
    end else begin
      case (state)
        IDLE: if (mrd_i | mwr_i) begin
          op_rd <= mrd_i;
          op_wr <= mwr_i;
          f3    <= funct3_i;
          addr  <= byte_addr_i;
          wd    <= wd_i;
          cnt   <= 4'(WAIT_CYCLES);
          state <= WAIT;
        end
        WAIT: if (cnt > 4'd1) cnt <= cnt - 4'd1;
        else begin
          cnt   <= '0;
          err_q <= bad;
          if (op_rd) rd_o <= bad ? '0 : ext;
          state <= (op_wr & ~bad & ~f3[1]) ? RMW : DONE;
        end
        RMW:     state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
  assign busy_o = state == WAIT | state == RMW;
  assign rdy_o  = state == DONE;
  assign err_o  = rdy_o & err_q;
endmodule
